stg_xt_seq: RTL
===============

// Module: stg_xt_seq
// PURPOSE
//  Parametrised translate stage, between decode-latch and ID. Expands ISA macro ops
//    (JSR/BSR/RET/PUSH/POP/SETSSP) into micro-op sequences of up to MAX_SEQ entries.
//  Over the first-generation translator it adds:
//    - valid qualification and a fetch-hold output;
//    - first/last/index tags per micro-op, so ID/EX can keep macros atomic;
//    - illegal-op flagging.
// PARAMETERS
//  DATA_W   24  instruction/micro-op width
//  ADDR_W   24  PC width
//  MAX_SEQ  8   max micro-ops per macro (>=4); IDX_W = $clog2(MAX_SEQ)
// PORTS
//  iw_clk       in   1        clock
//  iw_rst       in   1        reset, asynchronous, active-high
//  iw_pc        in   ADDR_W   PC of incoming instruction
//  iw_instr     in   DATA_W   incoming instruction
//  iw_valid     in   1        iw_instr/iw_pc meaningful this cycle
//  iw_flush     in   1        cancel everything in this stage
//  iw_stall     in   1        downstream stall; hold all state
//  ow_pc        out  ADDR_W   PC of emitted uop (macro PC for every uop of a sequence)
//  ow_instr     out  DATA_W   emitted micro-op
//  ow_valid     out  1        ow_instr meaningful
//  ow_first     out  1        uop is element 0 of its macro (1 for pass-through)
//  ow_last      out  1        uop is final element (1 for pass-through)
//  ow_uidx      out  IDX_W    element index within macro
//  ow_illegal   out  1        unknown opclass/subop; ow_instr is OPC_NOP
//  ow_hold_if   out  1        combinational; upstream must not advance iw_* this cycle
// BEHAVIOUR
//  Reset: all registered outputs 0 (ow_valid=0, ow_instr=0, ow_pc=0, flags 0); FSM IDLE.
//  Latency: 1 cycle, iw_* -> ow_*. All ow_* except ow_hold_if are registered.
//  FSM IDLE:
//   - iw_valid=0: latch bubble (ow_valid=0, ow_instr=NOP).
//   - len==1: pass-through, first=last=1, uidx=0. SETSSP rewrites to SRMOVAur SSP,AR; BTP -> NOP.
//   - len>1: emit element 0 (first=1, last=0), store list[1..len-1], cnt=len, idx=1,
//     pc_hold=iw_pc, go BUSY.
//  FSM BUSY: emit list[idx] with ow_pc=pc_hold and uidx=idx; last=1 when idx==cnt-1.
//   - idx+1<cnt: idx++.
//   - else: back to IDLE. iw_* is ignored throughout BUSY.
//  ow_hold_if = (IDLE & iw_valid & len>1) | (BUSY & idx+1<cnt) | iw_stall.
//   Fetch sees the next instruction exactly on the cycle the last uop latches.
//  Stall (iw_stall=1, no flush): every register holds, including outputs, idx, cnt, list.
//  Flush (priority over stall and start):
//   - next edge: ow_valid=0, ow_instr=0, flags 0, FSM IDLE, idx=cnt=0;
//   - an input present that cycle is dropped.
//  Illegal: unknown opclass/subop -> single NOP uop, ow_valid=1, ow_illegal=1, first=last=1.
//   Expander len==0 is treated the same way.
//  Widths: idx/cnt are IDX_W+1 internally, so cnt==MAX_SEQ is representable. Index compare
//   is unsigned. Immediates are sign-extended/truncated by the expander only.
//  Reset mid-sequence: sequence abandoned, IDLE, outputs cleared asynchronously.
//  Back-to-back macros: a new macro may start the cycle after the previous one's last uop.
//   No idle gap is required.
// STRUCTURE
//  Shared package (sizes/opcodes headers):
//   - opcode/subop/SR index macros;
//   - new XT_MAX_SEQ default;
//   - pack_* micro-op encoding functions, moved to shared include for reuse by assembler model.
//  Sub-module xt_expand (combinational): iw_instr -> {len, list[0:MAX_SEQ-1], illegal}.
//  stg_xt_seq holds only FSM, sequence buffer and output latches.
// TESTING
//  - Reset, then ADD pass-through at pc=0x000100 -> next cycle ow_valid=1, first=last=1,
//    uidx=0, ow_instr==input.
//  - JSRur A1 at pc=0x000200 -> 4 cycles: SRSUBsi SSP,#2; SRSTso SSP,LR,#0; SRMOVur LR,PC;
//    JCCur A1,AL. ow_pc=0x000200 all four; uidx 0..3; last only on 4th;
//    ow_hold_if high cycles 0-2.
//  - RET, iw_stall=1 on 2nd uop for 3 cycles -> SRLDso held 3 extra cycles.
//    Sequence then resumes with SRJCCso; total 3 distinct uops.
//  - PUSHur A3,D5 with iw_flush on cycle of uop1 -> next cycle ow_valid=0, FSM IDLE.
//    Following NOP passes through normally.
//  - Opclass/subop with no mapping -> ow_instr=NOP, ow_illegal=1, ow_valid=1.
//    iw_valid=0 -> ow_valid=0.
//  - POPur then PUSHAur back-to-back -> 4 uops, no bubble; asserting iw_rst mid-PUSHAur
//    -> all outputs 0 immediately.

Source files
------------

// File: rtl/stg_xt_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stg_xt_seq_pkg : sizes, opcode/subop/register indices, micro-op packers  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package stg_xt_seq_pkg;

    localparam int XT_DATA_W  = 24;
    localparam int XT_ADDR_W  = 24;
    localparam int XT_MAX_SEQ = 8;

    typedef logic [XT_DATA_W-1:0] xt_word_t;

    // Layout: [23:20] opclass, [19:16] subop, [15:12] ra, [11:8] rb, [7:0] imm
    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_ALU = 4'h1;
    localparam logic [3:0] OPC_SR  = 4'h2;
    localparam logic [3:0] OPC_JCC = 4'h3;
    localparam logic [3:0] OPC_MAC = 4'h4;

    localparam logic [3:0] ALU_SUB_MAX = 4'h7;

    localparam logic [3:0] SR_SUBSI  = 4'h0;
    localparam logic [3:0] SR_STSO   = 4'h1;
    localparam logic [3:0] SR_MOVUR  = 4'h2;
    localparam logic [3:0] SR_LDSO   = 4'h3;
    localparam logic [3:0] SR_JCCSO  = 4'h4;
    localparam logic [3:0] SR_MOVAUR = 4'h5;
    localparam logic [3:0] SR_ADDSI  = 4'h6;

    localparam logic [3:0] JCC_UR = 4'h0;
    localparam logic [3:0] JCC_SI = 4'h1;

    localparam logic [3:0] MAC_JSRUR   = 4'h0;
    localparam logic [3:0] MAC_BSR     = 4'h1;
    localparam logic [3:0] MAC_RET     = 4'h2;
    localparam logic [3:0] MAC_PUSHUR  = 4'h3;
    localparam logic [3:0] MAC_POPUR   = 4'h4;
    localparam logic [3:0] MAC_PUSHAUR = 4'h5;
    localparam logic [3:0] MAC_SETSSP  = 4'h6;
    localparam logic [3:0] MAC_BTP     = 4'h7;

    localparam logic [3:0] REG_NONE = 4'h0;
    localparam logic [3:0] REG_PC   = 4'hD;
    localparam logic [3:0] REG_LR   = 4'hE;
    localparam logic [3:0] REG_SSP  = 4'hF;
    localparam logic [3:0] CC_AL    = 4'h7;

    localparam xt_word_t XT_NOP = '0;

    typedef enum logic [0:0] {
        XT_IDLE = 1'b0,
        XT_BUSY = 1'b1
    } xt_state_e;

    function automatic xt_word_t pack_rri(input logic [3:0] opc, input logic [3:0] sub,
                                          input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [7:0] imm);
        return {opc, sub, ra, rb, imm};
    endfunction

    function automatic xt_word_t pack_rr(input logic [3:0] opc, input logic [3:0] sub,
                                         input logic [3:0] ra, input logic [3:0] rb);
        return pack_rri(opc, sub, ra, rb, 8'h00);
    endfunction

    function automatic xt_word_t pack_ri(input logic [3:0] opc, input logic [3:0] sub,
                                         input logic [3:0] ra, input logic [7:0] imm);
        return pack_rri(opc, sub, ra, REG_NONE, imm);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stg_xt_seq_xt_expand.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stg_xt_seq_xt_expand : combinational macro-op -> micro-op list expander  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stg_xt_seq_xt_expand
    import stg_xt_seq_pkg::*;
#(
    parameter int DATA_W  = XT_DATA_W,
    parameter int MAX_SEQ = XT_MAX_SEQ
) (
    input  logic [DATA_W-1:0]                instr_i,
    output logic [$clog2(MAX_SEQ):0]         len_o,
    output logic [MAX_SEQ-1:0][DATA_W-1:0]   list_o,
    output logic                             illegal_o
);

    localparam int IDX_W = $clog2(MAX_SEQ);

    xt_word_t   w;
    logic [3:0] opc;
    logic [3:0] sub;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] imm;

    assign w   = XT_DATA_W'(instr_i);
    assign opc = w[23:20];
    assign sub = w[19:16];
    assign ra  = w[15:12];
    assign rb  = w[11:8];
    assign imm = w[7:0];

    function automatic logic [DATA_W-1:0] uop(input xt_word_t x);
        return DATA_W'(x);
    endfunction

    // Illegal encodings leave len=1 with a NOP in slot 0, so len>1 never flags illegal.
    always_comb begin
        len_o     = (IDX_W+1)'(1);
        list_o    = '0;
        illegal_o = 1'b0;
        case (opc)
            OPC_NOP: begin
                if (sub == 4'h0) list_o[0] = instr_i;
                else             illegal_o = 1'b1;
            end
            OPC_ALU: begin
                if (sub <= ALU_SUB_MAX) list_o[0] = instr_i;
                else                    illegal_o = 1'b1;
            end
            OPC_SR: begin
                if (sub <= SR_ADDSI) list_o[0] = instr_i;
                else                 illegal_o = 1'b1;
            end
            OPC_JCC: begin
                if (sub <= JCC_SI) list_o[0] = instr_i;
                else               illegal_o = 1'b1;
            end
            OPC_MAC: begin
                case (sub)
                    MAC_JSRUR, MAC_BSR: begin
                        len_o     = (IDX_W+1)'(4);
                        list_o[0] = uop(pack_ri(OPC_SR, SR_SUBSI, REG_SSP, 8'h02));
                        list_o[1] = uop(pack_rr(OPC_SR, SR_STSO, REG_SSP, REG_LR));
                        list_o[2] = uop(pack_rr(OPC_SR, SR_MOVUR, REG_LR, REG_PC));
                        list_o[3] = (sub == MAC_JSRUR) ? uop(pack_rr(OPC_JCC, JCC_UR, ra, CC_AL))
                                                       : uop(pack_rri(OPC_JCC, JCC_SI, REG_PC, CC_AL, imm));
                    end
                    MAC_RET: begin
                        len_o     = (IDX_W+1)'(3);
                        list_o[0] = uop(pack_ri(OPC_SR, SR_ADDSI, REG_SSP, 8'h02));
                        list_o[1] = uop(pack_rri(OPC_SR, SR_LDSO, REG_LR, REG_SSP, 8'hFE));
                        list_o[2] = uop(pack_rr(OPC_SR, SR_JCCSO, REG_LR, CC_AL));
                    end
                    MAC_PUSHUR: begin
                        len_o     = (IDX_W+1)'(3);
                        list_o[0] = uop(pack_ri(OPC_SR, SR_SUBSI, REG_SSP, 8'h02));
                        list_o[1] = uop(pack_rri(OPC_SR, SR_STSO, REG_SSP, ra, 8'h00));
                        list_o[2] = uop(pack_rri(OPC_SR, SR_STSO, REG_SSP, rb, 8'h01));
                    end
                    MAC_POPUR: begin
                        len_o     = (IDX_W+1)'(2);
                        list_o[0] = uop(pack_rr(OPC_SR, SR_LDSO, ra, REG_SSP));
                        list_o[1] = uop(pack_ri(OPC_SR, SR_ADDSI, REG_SSP, 8'h01));
                    end
                    MAC_PUSHAUR: begin
                        len_o     = (IDX_W+1)'(2);
                        list_o[0] = uop(pack_ri(OPC_SR, SR_SUBSI, REG_SSP, 8'h01));
                        list_o[1] = uop(pack_rr(OPC_SR, SR_STSO, REG_SSP, ra));
                    end
                    MAC_SETSSP: list_o[0] = uop(pack_rr(OPC_SR, SR_MOVAUR, REG_SSP, ra));
                    MAC_BTP:    list_o[0] = uop(XT_NOP);
                    default:    illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stg_xt_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stg_xt_seq : translate stage sequencing macro ops into tagged micro-ops  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stg_xt_seq
    import stg_xt_seq_pkg::*;
#(
    parameter int DATA_W  = XT_DATA_W,
    parameter int ADDR_W  = XT_ADDR_W,
    parameter int MAX_SEQ = XT_MAX_SEQ
) (
    input  logic                        iw_clk,
    input  logic                        iw_rst,
    input  logic [ADDR_W-1:0]           iw_pc,
    input  logic [DATA_W-1:0]           iw_instr,
    input  logic                        iw_valid,
    input  logic                        iw_flush,
    input  logic                        iw_stall,
    output logic [ADDR_W-1:0]           ow_pc,
    output logic [DATA_W-1:0]           ow_instr,
    output logic                        ow_valid,
    output logic                        ow_first,
    output logic                        ow_last,
    output logic [$clog2(MAX_SEQ)-1:0]  ow_uidx,
    output logic                        ow_illegal,
    output logic                        ow_hold_if
);

    localparam int             IDX_W = $clog2(MAX_SEQ);
    localparam logic [IDX_W:0] ONE   = (IDX_W+1)'(1);

    xt_state_e                      state_q;
    logic [IDX_W:0]                 idx_q;
    logic [IDX_W:0]                 cnt_q;
    logic [IDX_W:0]                 idx_d;
    logic [MAX_SEQ-1:0][DATA_W-1:0] list_q;
    logic [ADDR_W-1:0]              pc_hold_q;

    logic [ADDR_W-1:0]              pc_q;
    logic [DATA_W-1:0]              instr_q;
    logic                           valid_q;
    logic                           first_q;
    logic                           last_q;
    logic [IDX_W-1:0]               uidx_q;
    logic                           illegal_q;

    logic [IDX_W:0]                 exp_len;
    logic [MAX_SEQ-1:0][DATA_W-1:0] exp_list;
    logic                           exp_illegal;
    logic                           seq_more;

    stg_xt_seq_xt_expand #(
        .DATA_W  (DATA_W),
        .MAX_SEQ (MAX_SEQ)
    ) u_xt_expand (
        .instr_i   (iw_instr),
        .len_o     (exp_len),
        .list_o    (exp_list),
        .illegal_o (exp_illegal)
    );

    assign idx_d    = idx_q + ONE;
    assign seq_more = idx_d < cnt_q;

    // Drops as the last uop is emitted so fetch advances on that same edge.
    assign ow_hold_if = ((state_q == XT_IDLE) && iw_valid && (exp_len > ONE))
                      || ((state_q == XT_BUSY) && seq_more)
                      || iw_stall;

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q   <= XT_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            list_q    <= '0;
            pc_hold_q <= '0;
            pc_q      <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            uidx_q    <= '0;
            illegal_q <= 1'b0;
        end else if (iw_flush) begin
            state_q   <= XT_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            pc_q      <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            uidx_q    <= '0;
            illegal_q <= 1'b0;
        end else if (!iw_stall) begin
            unique case (state_q)
                XT_IDLE: begin
                    pc_q   <= iw_pc;
                    uidx_q <= '0;
                    if (!iw_valid) begin
                        valid_q   <= 1'b0;
                        instr_q   <= DATA_W'(XT_NOP);
                        first_q   <= 1'b0;
                        last_q    <= 1'b0;
                        illegal_q <= 1'b0;
                    end else if (exp_illegal || (exp_len == '0)) begin
                        valid_q   <= 1'b1;
                        instr_q   <= DATA_W'(XT_NOP);
                        first_q   <= 1'b1;
                        last_q    <= 1'b1;
                        illegal_q <= 1'b1;
                    end else begin
                        valid_q   <= 1'b1;
                        instr_q   <= exp_list[0];
                        first_q   <= 1'b1;
                        illegal_q <= 1'b0;
                        if (exp_len == ONE) begin
                            last_q <= 1'b1;
                        end else begin
                            last_q    <= 1'b0;
                            list_q    <= exp_list;
                            cnt_q     <= exp_len;
                            idx_q     <= ONE;
                            pc_hold_q <= iw_pc;
                            state_q   <= XT_BUSY;
                        end
                    end
                end
                XT_BUSY: begin
                    valid_q   <= 1'b1;
                    pc_q      <= pc_hold_q;
                    instr_q   <= list_q[idx_q[IDX_W-1:0]];
                    uidx_q    <= idx_q[IDX_W-1:0];
                    first_q   <= 1'b0;
                    last_q    <= !seq_more;
                    illegal_q <= 1'b0;
                    if (seq_more) idx_q <= idx_d;
                    else          state_q <= XT_IDLE;
                end
                default: state_q <= XT_IDLE;
            endcase
        end
    end

    assign ow_pc      = pc_q;
    assign ow_instr   = instr_q;
    assign ow_valid   = valid_q;
    assign ow_first   = first_q;
    assign ow_last    = last_q;
    assign ow_uidx    = uidx_q;
    assign ow_illegal = illegal_q;

endmodule
`default_nettype wire
